// File: rtl/rx_bank_ctrl.sv
// rx_bank_ctrl: GMII receive-side capture controller.
// Finds preamble/SFD, writes frame bytes into one of two packet-buffer banks,
// checks length and error status, and hands completed frames to a consumer
// as {bank, length} descriptors through a two-entry queue. A bank stays owned
// by the consumer until it is explicitly released.

module rx_bank_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_dv,
    input  logic              rx_er,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic              frm_bank,
    output logic [ADDR_W-1:0] frm_len,
    input  logic              frm_rel,
    input  logic              frm_rel_bank,
    output logic [15:0]       frm_cnt,
    output logic [15:0]       drop_cnt,
    output logic [2:0]        drop_cause
);

    localparam logic [7:0]        PRE_BYTE = 8'h55;
    localparam logic [7:0]        SFD_BYTE = 8'hD5;
    localparam logic [ADDR_W-1:0] MAX_CNT  = ADDR_W'(MAX_LEN);
    localparam logic [ADDR_W-1:0] MIN_CNT  = ADDR_W'(MIN_LEN);

    localparam logic [2:0] CAUSE_NO_BANK  = 3'd1;
    localparam logic [2:0] CAUSE_RX_ER    = 3'd2;
    localparam logic [2:0] CAUSE_OVERSIZE = 3'd3;
    localparam logic [2:0] CAUSE_RUNT     = 3'd4;
    localparam logic [2:0] CAUSE_PREAMBLE = 3'd5;

    typedef enum logic [2:0] {SYNC, IDLE, PRE, DATA, DROP} state_t;

    // Bank life cycle: free -> being written -> queued as descriptor ->
    // delivered to consumer -> free again on release.
    typedef enum logic [1:0] {B_FREE, B_WRITE, B_QUEUED, B_OUT} bank_st_t;

    state_t            state;
    state_t            state_nx;
    bank_st_t          bank_st [2];
    logic              cur_bank;
    logic [ADDR_W-1:0] counter;

    logic              any_free;
    logic              free_bank;

    logic              do_claim;
    logic              do_write;
    logic              do_push;
    logic              do_discard;
    logic              do_drop;
    logic [2:0]        cause_nx;

    logic [1:0]             q_bank;
    logic [1:0][ADDR_W-1:0] q_len;
    logic                   q_rd_ptr;
    logic                   q_wr_ptr;
    logic [1:0]             q_cnt;
    logic                   q_pop;

    assign any_free  = (bank_st[0] == B_FREE) || (bank_st[1] == B_FREE);
    assign free_bank = (bank_st[0] == B_FREE) ? 1'b0 : 1'b1;

    assign frm_valid = (q_cnt != 2'd0);
    assign frm_bank  = q_bank[q_rd_ptr];
    assign frm_len   = q_len[q_rd_ptr];
    assign q_pop     = frm_valid && frm_ready;

    // Receive state register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= SYNC;
        else          state <= state_nx;
    end

    // Next-state decode and the per-cycle actions taken on the byte stream.
    always_comb begin
        state_nx   = state;
        do_claim   = 1'b0;
        do_write   = 1'b0;
        do_push    = 1'b0;
        do_discard = 1'b0;
        do_drop    = 1'b0;
        cause_nx   = 3'd0;
        case (state)
            SYNC: begin
                if (!rx_dv) state_nx = IDLE;
            end
            IDLE: begin
                if (rx_dv) begin
                    if (rx_data == PRE_BYTE) begin
                        state_nx = PRE;
                    end else begin
                        state_nx = DROP;
                        do_drop  = 1'b1;
                        cause_nx = CAUSE_PREAMBLE;
                    end
                end
            end
            PRE: begin
                if (!rx_dv) begin
                    state_nx = IDLE;
                    do_drop  = 1'b1;
                    cause_nx = CAUSE_PREAMBLE;
                end else if (rx_data == SFD_BYTE) begin
                    if (any_free) begin
                        state_nx = DATA;
                        do_claim = 1'b1;
                    end else begin
                        state_nx = DROP;
                        do_drop  = 1'b1;
                        cause_nx = CAUSE_NO_BANK;
                    end
                end else if (rx_data != PRE_BYTE) begin
                    state_nx = DROP;
                    do_drop  = 1'b1;
                    cause_nx = CAUSE_PREAMBLE;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_nx = IDLE;
                    if (counter >= MIN_CNT) begin
                        do_push = 1'b1;
                    end else begin
                        do_discard = 1'b1;
                        do_drop    = 1'b1;
                        cause_nx   = CAUSE_RUNT;
                    end
                end else if (rx_er) begin
                    state_nx   = DROP;
                    do_discard = 1'b1;
                    do_drop    = 1'b1;
                    cause_nx   = CAUSE_RX_ER;
                end else if (counter == MAX_CNT) begin
                    state_nx   = DROP;
                    do_discard = 1'b1;
                    do_drop    = 1'b1;
                    cause_nx   = CAUSE_OVERSIZE;
                end else begin
                    do_write = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) state_nx = IDLE;
            end
            default: state_nx = SYNC;
        endcase
    end

    // Bank ownership; a release only frees a bank the consumer already holds,
    // and being registered it is not visible to an SFD in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bank_st[0] <= B_FREE;
            bank_st[1] <= B_FREE;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (do_claim && (free_bank == 1'(b)))
                    bank_st[b] <= B_WRITE;
                else if (do_discard && (cur_bank == 1'(b)))
                    bank_st[b] <= B_FREE;
                else if (do_push && (cur_bank == 1'(b)))
                    bank_st[b] <= B_QUEUED;
                else if (q_pop && (frm_bank == 1'(b)))
                    bank_st[b] <= B_OUT;
                else if (frm_rel && (frm_rel_bank == 1'(b)) && (bank_st[b] == B_OUT))
                    bank_st[b] <= B_FREE;
            end
        end
    end

    // Current bank and byte offset of the frame being captured.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_bank <= 1'b0;
            counter  <= '0;
        end else if (do_claim) begin
            cur_bank <= free_bank;
            counter  <= '0;
        end else if (do_write) begin
            counter  <= counter + 1'b1;
        end
    end

    // Registered buffer write port, one strobe per accepted byte.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_bank <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_bank <= cur_bank;
                wr_addr <= counter;
                wr_data <= rx_data;
            end
        end
    end

    // Two-entry descriptor queue; only two banks exist so it never overflows.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_bank   <= '0;
            q_len    <= '0;
            q_rd_ptr <= 1'b0;
            q_wr_ptr <= 1'b0;
            q_cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                q_bank[q_wr_ptr] <= cur_bank;
                q_len[q_wr_ptr]  <= counter;
                q_wr_ptr         <= ~q_wr_ptr;
            end
            if (q_pop) q_rd_ptr <= ~q_rd_ptr;
            case ({do_push, q_pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Delivered-frame and drop statistics; the drop counter sticks at all ones.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frm_cnt    <= 16'd0;
            drop_cnt   <= 16'd0;
            drop_cause <= 3'd0;
        end else begin
            if (do_push) frm_cnt <= frm_cnt + 16'd1;
            if (do_drop) begin
                drop_cause <= cause_nx;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/rx_bank_ctrl.md
Name: rx_bank_ctrl

Overview:
Receive-side controller for the GMII capture path. It detects preamble/SFD on the byte stream, writes each frame's bytes into one of two packet-buffer banks, and validates frame length and error status. Completed frames are handed to a downstream consumer as descriptors, oldest first. The consumer holds a bank until it releases it explicitly, which allows ping-pong capture while the previous frame is read out.

Parameters:
ADDR_W, 11, byte-address width per bank (2048 bytes/bank)
MAX_LEN, 1518, maximum accepted frame length in bytes after SFD, FCS included; must be < 2^ADDR_W
MIN_LEN, 64, minimum accepted frame length in bytes after SFD, FCS included

Ports:
clock  in  1  system clock; all rx inputs are synchronous to it
reset_n  in  1  synchronous active-low reset
rx_dv  in  1  receive data valid
rx_er  in  1  receive error
rx_data  in  8  receive byte
wr_en  out  1  buffer write strobe
wr_bank  out  1  bank being written
wr_addr  out  ADDR_W  byte offset in bank
wr_data  out  8  byte to write
frm_valid  out  1  descriptor available
frm_ready  in  1  consumer accepts descriptor
frm_bank  out  1  bank holding the frame
frm_len  out  ADDR_W  frame length in bytes
frm_rel  in  1  one-cycle pulse: consumer frees a bank
frm_rel_bank  in  1  bank being freed
frm_cnt  out  16  frames delivered, wraps
drop_cnt  out  16  frames dropped, saturates at 0xFFFF
drop_cause  out  3  cause of last drop: 0 none, 1 no bank, 2 rx_er, 3 oversize, 4 runt, 5 bad preamble

Behaviour:
- Interface: clock is clock; reset is reset_n, synchronous, active-low.
- Reset values: all outputs 0, both banks free, descriptor queue empty, state SYNC.
- State machine:
  - SYNC: wait for rx_dv=0, then go to IDLE. This discards any frame already in progress at reset. No counting in SYNC.
  - IDLE: rx_dv=1 with 0x55 → PRE. rx_dv=1 with any other byte → DROP, cause 5.
  - PRE:
    - 0x55 → stay in PRE.
    - 0xD5 with a free bank → DATA. Select the lowest-numbered free bank; byte counter = 0.
    - 0xD5 with no free bank → DROP, cause 1.
    - Any other byte → DROP, cause 5.
    - rx_dv=0 → IDLE, drop counted, cause 5.
  - DATA, rx_dv=1 with rx_er=0:
    - Write the byte at offset = counter, then increment the counter.
    - A byte arriving when counter == MAX_LEN is not written → DROP, cause 3.
  - DATA, rx_dv=1 with rx_er=1 → DROP, cause 2. The byte is not written.
  - DATA, rx_dv=0 (frame end):
    - counter ≥ MIN_LEN: bank marked full, descriptor {bank, counter} pushed, frm_cnt++ → IDLE.
    - Otherwise: bank stays free → IDLE, drop counted, cause 4.
  - DROP: drop_cnt++ and drop_cause updated on the entry cycle. Any partially written bank is returned to free. Wait for rx_dv=0, then go to IDLE.
- Write path latency: a byte sampled at edge n drives wr_en/wr_bank/wr_addr/wr_data after edge n. wr_en is high exactly one cycle per accepted byte.
- Descriptor latency: frame end sampled at edge n gives frm_valid=1 after edge n, provided the queue was empty.
- Descriptor queue:
  - Depth 2 FIFO, oldest first.
  - frm_valid/frm_bank/frm_len are held stable until frm_valid & frm_ready.
  - A push and a pop in the same cycle are both honoured.
  - The queue cannot overflow, because there are only 2 banks.
- Bank ownership: a bank is busy from SFD until the frm_rel pulse naming it, or until its frame is discarded.
  - A release of a bank that is not delivered-and-unreleased is ignored.
  - A release takes effect from the next cycle. A release coinciding with an SFD does not make that bank available to that SFD.
- Drop counter: saturates at 0xFFFF. drop_cause holds its value until the next drop.
- Reset mid-frame: all state is cleared, then SYNC. No partial descriptor or write is emitted after reset.

Test Plan:
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F, rx_dv drops → 64 writes to bank 0, addr 0..63; frm_valid next cycle with bank 0, len 64; frm_cnt=1.
- Two 100-byte frames, frm_ready=0 → banks 0 then 1 filled. A third frame → drop_cnt=1, cause 1, no writes. Accept both, release bank 0, send a fourth frame → written to bank 0.
- 1519 data bytes → writes to addr 0..1517 only; DROP cause 3; no descriptor; bank 0 free again.
- rx_er asserted at byte 20 → DROP cause 2; a following 64-byte frame lands in bank 0.
- 40-byte frame → cause 4, drop_cnt=1. Preamble 0x55,0x57 → cause 5.
- reset_n low at data byte 30 with rx_dv held high, then the frame continues → no writes until rx_dv=0; the next frame is captured normally.
